// File: rtl/pe_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : pe_commit_stage
// Purpose  : Merges per-instruction ALU results into per-channel FWFT FIFOs
//            and the hi/lo stored-data register, with sticky error flags.
// Revision : 1.0
// ============================================================================
module pe_commit_stage #(
  parameter int DATA_W     = 16,
  parameter int NUM_INSTS  = 2,
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_INSTS*DATA_W-1:0]   inst_res,
  input  logic [NUM_INSTS*NUM_CH-1:0]   inst_ch_we,
  input  logic [NUM_INSTS-1:0]          inst_hi_we,
  input  logic [NUM_INSTS*DATA_W/2-1:0] inst_hi_d,
  input  logic [NUM_INSTS-1:0]          inst_lo_we,
  input  logic [NUM_INSTS*DATA_W/2-1:0] inst_lo_d,
  output logic [NUM_CH*DATA_W-1:0]      ch_data,
  output logic [NUM_CH-1:0]             ch_ready,
  input  logic [NUM_CH-1:0]             ch_read,
  output logic [NUM_CH-1:0]             ch_full,
  output logic [DATA_W-1:0]             stored_data,
  output logic [NUM_CH+1:0]             err_conflict,
  output logic [NUM_CH-1:0]             err_overflow
);
  localparam int HALF_W = DATA_W / 2;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic              req;
      logic              multi;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr;
      logic [PTR_W-1:0]  rd_ptr;
      logic [CNT_W-1:0]  count;
      logic              full;
      logic              ready;
      logic              push;
      logic              pop;
      logic              conf_q;
      logic              ovf_q;

      // Lowest-numbered requesting instruction owns the channel this cycle.
      always_comb begin
        req   = 1'b0;
        multi = 1'b0;
        wdata = '0;
        for (int i = 0; i < NUM_INSTS; i++) begin
          if (inst_ch_we[i*NUM_CH + c]) begin
            if (req) begin
              multi = 1'b1;
            end else begin
              req   = 1'b1;
              wdata = inst_res[i*DATA_W +: DATA_W];
            end
          end
        end
      end

      // Full is taken from the registered count, so a same-cycle pop never frees a slot.
      assign full  = (count == FULL_CNT);
      assign ready = (count != '0);
      assign push  = req && !full;
      assign pop   = ch_read[c] && ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
          conf_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else begin
          if (push) wr_ptr <= wr_ptr + PTR_W'(1);
          if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
          if (push && !pop)      count <= count + CNT_W'(1);
          else if (pop && !push) count <= count - CNT_W'(1);
          if (multi)        conf_q <= 1'b1;
          if (req && full)  ovf_q  <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
      end

      assign ch_data[c*DATA_W +: DATA_W] = mem[rd_ptr];
      assign ch_ready[c]     = ready;
      assign ch_full[c]      = full;
      assign err_conflict[c] = conf_q;
      assign err_overflow[c] = ovf_q;
    end
  endgenerate

  logic              hi_we;
  logic              hi_multi;
  logic [HALF_W-1:0] hi_val;
  logic              lo_we;
  logic              lo_multi;
  logic [HALF_W-1:0] lo_val;
  logic              conf_hi_q;
  logic              conf_lo_q;

  // Hi and lo halves arbitrate independently with the same lowest-index priority.
  always_comb begin
    hi_we    = 1'b0;
    hi_multi = 1'b0;
    hi_val   = '0;
    lo_we    = 1'b0;
    lo_multi = 1'b0;
    lo_val   = '0;
    for (int i = 0; i < NUM_INSTS; i++) begin
      if (inst_hi_we[i]) begin
        if (hi_we) begin
          hi_multi = 1'b1;
        end else begin
          hi_we  = 1'b1;
          hi_val = inst_hi_d[i*HALF_W +: HALF_W];
        end
      end
      if (inst_lo_we[i]) begin
        if (lo_we) begin
          lo_multi = 1'b1;
        end else begin
          lo_we  = 1'b1;
          lo_val = inst_lo_d[i*HALF_W +: HALF_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stored_data <= '0;
      conf_hi_q   <= 1'b0;
      conf_lo_q   <= 1'b0;
    end else begin
      if (hi_we)    stored_data[DATA_W-1:HALF_W] <= hi_val;
      if (lo_we)    stored_data[HALF_W-1:0]      <= lo_val;
      if (hi_multi) conf_hi_q <= 1'b1;
      if (lo_multi) conf_lo_q <= 1'b1;
    end
  end

  assign err_conflict[NUM_CH]   = conf_hi_q;
  assign err_conflict[NUM_CH+1] = conf_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_commit_stage
// Purpose  : Scoreboard bench for pe_commit_stage at default and wide parameters.
// Revision : 1.0
// ============================================================================
module tb_pe_commit_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults (2 insts, 8 ch, depth 2)
  logic [31:0]  a_res;
  logic [15:0]  a_we;
  logic [1:0]   a_hwe, a_lwe;
  logic [15:0]  a_hd, a_ld;
  logic [7:0]   a_rd;
  logic [127:0] a_data;
  logic [7:0]   a_ready, a_full, a_ov;
  logic [15:0]  a_st;
  logic [9:0]   a_conf;

  // Instance B: 4 insts, 4 ch, depth 8
  logic [63:0]  b_res;
  logic [15:0]  b_we;
  logic [3:0]   b_hwe, b_lwe;
  logic [31:0]  b_hd, b_ld;
  logic [3:0]   b_rd;
  logic [63:0]  b_data;
  logic [3:0]   b_ready, b_full, b_ov;
  logic [15:0]  b_st;
  logic [5:0]   b_conf;

  pe_commit_stage #(.DATA_W(16), .NUM_INSTS(2), .NUM_CH(8), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .inst_res(a_res), .inst_ch_we(a_we),
    .inst_hi_we(a_hwe), .inst_hi_d(a_hd), .inst_lo_we(a_lwe), .inst_lo_d(a_ld),
    .ch_data(a_data), .ch_ready(a_ready), .ch_read(a_rd), .ch_full(a_full),
    .stored_data(a_st), .err_conflict(a_conf), .err_overflow(a_ov)
  );

  pe_commit_stage #(.DATA_W(16), .NUM_INSTS(4), .NUM_CH(4), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .inst_res(b_res), .inst_ch_we(b_we),
    .inst_hi_we(b_hwe), .inst_hi_d(b_hd), .inst_lo_we(b_lwe), .inst_lo_d(b_ld),
    .ch_data(b_data), .ch_ready(b_ready), .ch_read(b_rd), .ch_full(b_full),
    .stored_data(b_st), .err_conflict(b_conf), .err_overflow(b_ov)
  );

  int nvec = 0;
  int nerr = 0;

  logic [15:0] q [8][$];
  logic [9:0]  m_conf;
  logic [7:0]  m_ov;
  logic [15:0] m_st;
  logic [15:0] qb [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_res = '0; a_we = '0; a_hwe = '0; a_lwe = '0; a_hd = '0; a_ld = '0; a_rd = '0;
  endtask

  task automatic clear_model();
    for (int c = 0; c < 8; c++) q[c].delete();
    qb.delete();
    m_conf = '0;
    m_ov   = '0;
    m_st   = '0;
  endtask

  // Drives one cycle on instance A and updates the reference model.
  task automatic cyc(input logic [31:0] r, input logic [15:0] we,
                     input logic [1:0] hwe, input logic [15:0] hd,
                     input logic [1:0] lwe, input logic [15:0] ld,
                     input logic [7:0] rd);
    int          n;
    logic [15:0] w;
    logic [7:0]  hb, lb;
    bit          was_full;
    a_res = r; a_we = we; a_hwe = hwe; a_hd = hd; a_lwe = lwe; a_ld = ld; a_rd = rd;
    for (int c = 0; c < 8; c++) begin
      n = 0; w = '0;
      for (int i = 1; i >= 0; i--) if (we[i*8 + c]) begin n++; w = r[i*16 +: 16]; end
      was_full = (q[c].size() == 2);
      if (rd[c] && q[c].size() > 0) void'(q[c].pop_front());
      if (n >= 2) m_conf[c] = 1'b1;
      if (n >= 1) begin
        if (was_full) m_ov[c] = 1'b1;
        else          q[c].push_back(w);
      end
    end
    n = 0; hb = '0;
    for (int i = 1; i >= 0; i--) if (hwe[i]) begin n++; hb = hd[i*8 +: 8]; end
    if (n >= 1) m_st[15:8] = hb;
    if (n >= 2) m_conf[8] = 1'b1;
    n = 0; lb = '0;
    for (int i = 1; i >= 0; i--) if (lwe[i]) begin n++; lb = ld[i*8 +: 8]; end
    if (n >= 1) m_st[7:0] = lb;
    if (n >= 2) m_conf[9] = 1'b1;
    step();
    idle_a();
  endtask

  task automatic do_reset();
    idle_a();
    b_res = '0; b_we = '0; b_hwe = '0; b_lwe = '0; b_hd = '0; b_ld = '0; b_rd = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (a_ready !== 8'h00) begin nerr++; $display("FAIL reset_ready got %h exp 00", a_ready); end
    nvec++; if (a_full !== 8'h00) begin nerr++; $display("FAIL reset_full got %h exp 00", a_full); end
    nvec++; if (a_st !== 16'h0000) begin nerr++; $display("FAIL reset_stored got %h exp 0000", a_st); end
    nvec++; if (a_conf !== 10'h000) begin nerr++; $display("FAIL reset_conf got %h exp 000", a_conf); end
    nvec++; if (a_ov !== 8'h00) begin nerr++; $display("FAIL reset_ov got %h exp 00", a_ov); end
    nvec++; if ({b_ready, b_full, b_ov, b_conf} !== 18'h0) begin nerr++;
      $display("FAIL reset_b got %h exp 0", {b_ready, b_full, b_ov, b_conf}); end
  endtask

  task automatic test_single_write();
    cyc({16'h0000, 16'hA5A5}, 16'h0004, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    nvec++; if (a_ready !== 8'h04) begin nerr++; $display("FAIL single_ready got %h exp 04", a_ready); end
    nvec++; if (a_data[2*16 +: 16] !== q[2][0]) begin nerr++;
      $display("FAIL single_data got %h exp %h", a_data[2*16 +: 16], q[2][0]); end
    cyc(32'h0, 16'h0, 2'b0, 16'h0, 2'b0, 16'h0, 8'h04);
    nvec++; if (a_ready[2] !== 1'b0) begin nerr++; $display("FAIL single_pop got %b exp 0", a_ready[2]); end
  endtask

  task automatic test_overflow();
    cyc(32'h0000_0001, 16'h0001, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    cyc(32'h0000_0002, 16'h0001, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    nvec++; if (a_full[0] !== (q[0].size() == 2)) begin nerr++; $display("FAIL ovf_full got %b exp 1", a_full[0]); end
    cyc(32'h0000_0003, 16'h0001, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    nvec++; if (a_ov !== m_ov) begin nerr++; $display("FAIL ovf_flag got %h exp %h", a_ov, m_ov); end
    for (int k = 0; k < 2; k++) begin
      nvec++; if (a_data[15:0] !== q[0][0]) begin nerr++;
        $display("FAIL ovf_pop%0d got %h exp %h", k, a_data[15:0], q[0][0]); end
      cyc(32'h0, 16'h0, 2'b0, 16'h0, 2'b0, 16'h0, 8'h01);
    end
    nvec++; if (a_ready[0] !== 1'b0) begin nerr++; $display("FAIL ovf_drained got %b exp 0", a_ready[0]); end
  endtask

  task automatic test_conflict();
    cyc({16'h2222, 16'h1111}, 16'h2020, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    nvec++; if (a_conf !== m_conf) begin nerr++; $display("FAIL conf_flag got %h exp %h", a_conf, m_conf); end
    nvec++; if (a_ready !== 8'h20) begin nerr++; $display("FAIL conf_ready got %h exp 20", a_ready); end
    nvec++; if (a_data[5*16 +: 16] !== q[5][0]) begin nerr++;
      $display("FAIL conf_data got %h exp %h", a_data[5*16 +: 16], q[5][0]); end
    cyc(32'h0, 16'h0, 2'b0, 16'h0, 2'b0, 16'h0, 8'h20);
    nvec++; if (a_ready[5] !== 1'b0) begin nerr++; $display("FAIL conf_single got %b exp 0", a_ready[5]); end
  endtask

  task automatic test_stored();
    cyc(32'h0, 16'h0, 2'b01, {8'hEE, 8'h12}, 2'b10, {8'h34, 8'hDD}, 8'h00);
    nvec++; if (a_st !== m_st) begin nerr++; $display("FAIL stored_split got %h exp %h", a_st, m_st); end
    nvec++; if (a_conf !== m_conf) begin nerr++; $display("FAIL stored_noerr got %h exp %h", a_conf, m_conf); end
    cyc(32'h0, 16'h0, 2'b11, {8'h56, 8'h78}, 2'b00, 16'h0, 8'h00);
    nvec++; if (a_st !== m_st) begin nerr++; $display("FAIL stored_hi_conf got %h exp %h", a_st, m_st); end
    nvec++; if (a_conf !== m_conf) begin nerr++; $display("FAIL stored_conf got %h exp %h", a_conf, m_conf); end
  endtask

  task automatic test_push_pop();
    cyc(32'h0000_00AA, 16'h0080, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    nvec++; if (a_data[7*16 +: 16] !== q[7][0]) begin nerr++;
      $display("FAIL pp_head0 got %h exp %h", a_data[7*16 +: 16], q[7][0]); end
    cyc(32'h0000_00BB, 16'h0080, 2'b0, 16'h0, 2'b0, 16'h0, 8'h80);
    nvec++; if ({a_ready[7], a_full[7]} !== 2'b10) begin nerr++;
      $display("FAIL pp_count got %b exp 10", {a_ready[7], a_full[7]}); end
    nvec++; if (a_data[7*16 +: 16] !== q[7][0]) begin nerr++;
      $display("FAIL pp_head1 got %h exp %h", a_data[7*16 +: 16], q[7][0]); end
    cyc(32'h0, 16'h0, 2'b0, 16'h0, 2'b0, 16'h0, 8'h08);
    nvec++; if ({a_ready, a_full, a_ov, a_conf} !== {8'h80, 8'h00, m_ov, m_conf}) begin nerr++;
      $display("FAIL pp_empty_pop got %h exp %h", {a_ready, a_full, a_ov, a_conf}, {8'h80, 8'h00, m_ov, m_conf}); end
    cyc(32'h0, 16'h0, 2'b0, 16'h0, 2'b0, 16'h0, 8'h80);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  er, ef;
    logic [15:0] we;
    for (int t = 0; t < 60; t++) begin
      er = '0; ef = '0;
      for (int c = 0; c < 8; c++) begin
        er[c] = (q[c].size() > 0);
        ef[c] = (q[c].size() == 2);
      end
      nvec++; if ({a_ready, a_full} !== {er, ef}) begin nerr++;
        $display("FAIL b2b_flags t=%0d got %h exp %h", t, {a_ready, a_full}, {er, ef}); end
      for (int c = 0; c < 8; c++) begin
        if (q[c].size() > 0) begin
          nvec++; if (a_data[c*16 +: 16] !== q[c][0]) begin nerr++;
            $display("FAIL b2b_head t=%0d ch%0d got %h exp %h", t, c, a_data[c*16 +: 16], q[c][0]); end
        end
      end
      we = '0;
      we[1]  = ($urandom_range(0, 1) == 1);
      we[6]  = ($urandom_range(0, 2) == 0);
      we[9]  = ($urandom_range(0, 3) == 0);
      we[14] = ($urandom_range(0, 1) == 1);
      cyc($urandom, we, 2'b0, 16'h0, 2'b0, 16'h0, 8'($urandom_range(0, 255)) & 8'h42);
    end
    nvec++; if ({a_conf, a_ov} !== {m_conf, m_ov}) begin nerr++;
      $display("FAIL b2b_err got %h exp %h", {a_conf, a_ov}, {m_conf, m_ov}); end
  endtask

  task automatic test_reset_mid();
    cyc(32'h1234_0001, 16'h0111, 2'b11, 16'hFFFF, 2'b11, 16'hFFFF, 8'h00);
    cyc(32'h1234_0002, 16'h0111, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    cyc(32'h1234_0003, 16'h0111, 2'b0, 16'h0, 2'b0, 16'h0, 8'h00);
    nvec++; if ({a_full[4], a_full[0], a_ov[0], a_conf[0]} !== 4'b1111) begin nerr++;
      $display("FAIL rmid_setup got %b exp 1111", {a_full[4], a_full[0], a_ov[0], a_conf[0]}); end
    rst = 1'b1;
    a_res = 32'hFFFF_FFFF; a_we = 16'hFFFF; a_hwe = 2'b11; a_hd = 16'hABCD; a_lwe = 2'b11; a_ld = 16'hABCD;
    step();
    rst = 1'b0;
    idle_a();
    clear_model();
    nvec++; if ({a_ready, a_full, a_ov, a_conf, a_st} !== 50'h0) begin nerr++;
      $display("FAIL rmid_clear got %h exp 0", {a_ready, a_full, a_ov, a_conf, a_st}); end
  endtask

  task automatic test_wide_params();
    logic [3:0] eov;
    eov = '0;
    for (int k = 0; k < 9; k++) begin
      b_res = {16'h0100 + 16'(k), 48'h0};
      b_we  = 16'h4000;
      if (qb.size() < 8) qb.push_back(16'h0100 + 16'(k));
      else eov[2] = 1'b1;
      step();
    end
    b_we = '0;
    nvec++; if ({b_full, b_ov} !== {4'b0100, eov}) begin nerr++;
      $display("FAIL wide_full got %h exp %h", {b_full, b_ov}, {4'b0100, eov}); end
    b_res = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    b_we  = 16'h1110;
    b_hwe = 4'hF; b_hd = {8'h44, 8'h33, 8'h22, 8'h11};
    b_lwe = 4'b0100; b_ld = {8'h00, 8'h77, 8'h00, 8'h00};
    step();
    b_we = '0; b_hwe = '0; b_lwe = '0;
    nvec++; if (b_conf !== 6'b010001) begin nerr++; $display("FAIL wide_conf got %b exp 010001", b_conf); end
    nvec++; if (b_st !== 16'h1177) begin nerr++; $display("FAIL wide_stored got %h exp 1177", b_st); end
    nvec++; if (b_data[15:0] !== 16'h2222) begin nerr++; $display("FAIL wide_winner got %h exp 2222", b_data[15:0]); end
    for (int k = 0; k < 8; k++) begin
      nvec++; if (b_data[2*16 +: 16] !== qb[0]) begin nerr++;
        $display("FAIL wide_drain%0d got %h exp %h", k, b_data[2*16 +: 16], qb[0]); end
      void'(qb.pop_front());
      b_rd = 4'b0100;
      step();
      b_rd = '0;
    end
    nvec++; if (b_ready !== 4'b0001) begin nerr++; $display("FAIL wide_drained got %b exp 0001", b_ready); end
    b_res = {48'h0, 16'h5555}; b_we = 16'h0001; b_rd = 4'b0001;
    step();
    b_we = '0; b_rd = '0;
    nvec++; if ({b_ready[0], b_full[0], b_data[15:0]} !== {2'b10, 16'h5555}) begin nerr++;
      $display("FAIL wide_pushpop got %h exp %h", {b_ready[0], b_full[0], b_data[15:0]}, {2'b10, 16'h5555}); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_conflict();
    test_stored();
    test_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_wide_params();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
